// File: rtl/wb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// wb_mem_arbiter
//
// Two-master / one-slave Wishbone classic arbiter. The instruction-fetch
// master (inst_*) and the data master (data_*) share one memory slave port
// (mem_*). Only one transaction is in flight at a time. Simultaneous requests
// are resolved round-robin, or always in favour of the data master when
// DATA_PRIORITY is set. A silent slave is abandoned after TIMEOUT_CYCLES
// grant cycles, and the granted master then receives a one-cycle err pulse.
//
// Parameters
//   ADDR_WIDTH     address width
//   DATA_WIDTH     data width (byte selects are DATA_WIDTH/8 wide)
//   TIMEOUT_CYCLES grant cycles without mem_ack before err (2..65535)
//   DATA_PRIORITY  0 = round-robin on ties, 1 = data master wins ties
//
// Ports
//   clk_core, rst_core          clock, synchronous active-high reset
//   inst_cyc/stb/we/sel/addr/data_w   instruction master request
//   inst_data_r/ack/err               instruction master response
//   data_cyc/stb/we/sel/addr/data_w   data master request
//   data_data_r/ack/err               data master response
//   mem_cyc/stb/we/sel/addr/data_w    slave request
//   mem_data_r, mem_ack               slave response
// ---------------------------------------------------------------------------
module wb_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DATA_PRIORITY  = 0
) (
  input  logic                    clk_core,
  input  logic                    rst_core,

  // instruction master
  input  logic                    inst_cyc,
  input  logic                    inst_stb,
  input  logic                    inst_we,
  input  logic [DATA_WIDTH/8-1:0] inst_sel,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  input  logic [DATA_WIDTH-1:0]   inst_data_w,
  output logic [DATA_WIDTH-1:0]   inst_data_r,
  output logic                    inst_ack,
  output logic                    inst_err,

  // data master
  input  logic                    data_cyc,
  input  logic                    data_stb,
  input  logic                    data_we,
  input  logic [DATA_WIDTH/8-1:0] data_sel,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_data_w,
  output logic [DATA_WIDTH-1:0]   data_data_r,
  output logic                    data_ack,
  output logic                    data_err,

  // memory slave
  output logic                    mem_cyc,
  output logic                    mem_stb,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_sel,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data_w,
  input  logic [DATA_WIDTH-1:0]   mem_data_r,
  input  logic                    mem_ack
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  // Counter value during the last grant cycle before the slave is abandoned.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  // Saturation ceiling; the counter never wraps back to zero.
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2
  } state_t;

  // last_reg: 1 = data master was served most recently, 0 = inst master.
  state_t                  state_reg, state_next;
  logic                    last_reg, last_next;
  logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;

  // Request copy latched at grant time; the slave only ever sees this copy.
  logic                    we_reg, we_next;
  logic [SEL_WIDTH-1:0]    sel_reg, sel_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;

  // Error pulses are registered so they appear the cycle after expiry,
  // while the FSM is already back in IDLE and no ack can coincide.
  logic                    inst_err_reg, inst_err_next;
  logic                    data_err_reg, data_err_next;

  logic                    inst_req;
  logic                    data_req;
  logic                    pick_data;
  logic                    granted_cyc;
  logic                    grant_inst;
  logic                    grant_data;
  logic                    busy;

  assign inst_req = inst_cyc & inst_stb;
  assign data_req = data_cyc & data_stb;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;   // inst wins the first tie after reset
      cnt_reg      <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      inst_err_reg <= 1'b0;
      data_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      cnt_reg      <= cnt_next;
      we_reg       <= we_next;
      sel_reg      <= sel_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      inst_err_reg <= inst_err_next;
      data_err_reg <= data_err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    cnt_next      = cnt_reg;
    we_next       = we_reg;
    sel_next      = sel_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    inst_err_next = 1'b0;
    data_err_next = 1'b0;
    pick_data     = 1'b0;
    granted_cyc   = 1'b0;

    case (state_reg)
      IDLE: begin
        // A stray mem_ack here is simply ignored.
        if (inst_req || data_req) begin
          if (inst_req && data_req) begin
            pick_data = (DATA_PRIORITY != 0) ? 1'b1 : ~last_reg;
          end else begin
            pick_data = data_req;
          end

          state_next = pick_data ? GRANT_DATA : GRANT_INST;
          last_next  = pick_data;
          cnt_next   = '0;
          we_next    = pick_data ? data_we     : inst_we;
          sel_next   = pick_data ? data_sel    : inst_sel;
          addr_next  = pick_data ? data_addr   : inst_addr;
          wdata_next = pick_data ? data_data_w : inst_data_w;
        end
      end

      GRANT_INST, GRANT_DATA: begin
        granted_cyc = (state_reg == GRANT_DATA) ? data_cyc : inst_cyc;

        if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CNT_WIDTH'(1);
        end

        // Ack (or abort) takes precedence over an expiring timeout.
        if (mem_ack || !granted_cyc) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          if (state_reg == GRANT_DATA) begin
            data_err_next = 1'b1;
          end else begin
            inst_err_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign grant_inst = (state_reg == GRANT_INST);
  assign grant_data = (state_reg == GRANT_DATA);
  assign busy       = grant_inst | grant_data;

  // The slave port is driven only while a grant is active; otherwise all
  // request signals sit at zero, which also gives the mandatory idle cycle.
  assign mem_cyc    = busy;
  assign mem_stb    = busy;
  assign mem_we     = busy & we_reg;
  assign mem_sel    = busy ? sel_reg   : '0;
  assign mem_addr   = busy ? addr_reg  : '0;
  assign mem_data_w = busy ? wdata_reg : '0;

  // Read data goes to both masters unqualified; ack tells them when to use it.
  assign inst_data_r = mem_data_r;
  assign data_data_r = mem_data_r;

  // An aborting master (cyc already low) is never handed an ack.
  assign inst_ack = grant_inst & inst_cyc & mem_ack;
  assign data_ack = grant_data & data_cyc & mem_ack;

  assign inst_err = inst_err_reg;
  assign data_err = data_err_reg;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        inst_cyc = 1'b0, inst_stb = 1'b0, inst_we = 1'b0;
  logic [3:0]  inst_sel = 4'h0;
  logic [31:0] inst_addr = '0, inst_data_w = '0;
  logic        data_cyc = 1'b0, data_stb = 1'b0, data_we = 1'b0;
  logic [3:0]  data_sel = 4'h0;
  logic [31:0] data_addr = '0, data_data_w = '0;
  logic [31:0] mem_data_r = 32'h5A5A5A5A;

  // instance A: TIMEOUT_CYCLES=8, round-robin
  logic [31:0] a_inst_data_r, a_data_data_r, a_mem_addr, a_mem_data_w;
  logic        a_inst_ack, a_inst_err, a_data_ack, a_data_err;
  logic        a_mem_cyc, a_mem_stb, a_mem_we, a_mem_ack;
  logic [3:0]  a_mem_sel;
  // instance B: data priority
  logic [31:0] b_inst_data_r, b_data_data_r, b_mem_addr, b_mem_data_w;
  logic        b_inst_ack, b_inst_err, b_data_ack, b_data_err;
  logic        b_mem_cyc, b_mem_stb, b_mem_we, b_mem_ack;
  logic [3:0]  b_mem_sel;

  // slave models
  int          a_wait = 0, b_wait = 0;
  logic        a_ack_auto = 1'b0, b_ack_auto = 1'b0;
  logic        slave_en = 1'b0;
  int          ack_delay = 1;
  logic        stray_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a_mem_ack = a_ack_auto | stray_ack;
  assign b_mem_ack = b_ack_auto;

  always @(posedge clk) begin
    if (rst || !a_mem_stb || a_ack_auto) begin
      a_wait     <= 0;
      a_ack_auto <= 1'b0;
    end else begin
      a_wait     <= a_wait + 1;
      a_ack_auto <= slave_en && (a_wait + 1 == ack_delay);
    end
  end

  always @(posedge clk) begin
    if (rst || !b_mem_stb || b_ack_auto) begin
      b_wait     <= 0;
      b_ack_auto <= 1'b0;
    end else begin
      b_wait     <= b_wait + 1;
      b_ack_auto <= (b_wait + 1 == 1);
    end
  end

  wb_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .DATA_PRIORITY(0)) dut_a (
    .clk_core(clk), .rst_core(rst),
    .inst_cyc(inst_cyc), .inst_stb(inst_stb), .inst_we(inst_we), .inst_sel(inst_sel),
    .inst_addr(inst_addr), .inst_data_w(inst_data_w), .inst_data_r(a_inst_data_r),
    .inst_ack(a_inst_ack), .inst_err(a_inst_err),
    .data_cyc(data_cyc), .data_stb(data_stb), .data_we(data_we), .data_sel(data_sel),
    .data_addr(data_addr), .data_data_w(data_data_w), .data_data_r(a_data_data_r),
    .data_ack(a_data_ack), .data_err(a_data_err),
    .mem_cyc(a_mem_cyc), .mem_stb(a_mem_stb), .mem_we(a_mem_we), .mem_sel(a_mem_sel),
    .mem_addr(a_mem_addr), .mem_data_w(a_mem_data_w), .mem_data_r(mem_data_r),
    .mem_ack(a_mem_ack)
  );

  wb_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .DATA_PRIORITY(1)) dut_b (
    .clk_core(clk), .rst_core(rst),
    .inst_cyc(inst_cyc), .inst_stb(inst_stb), .inst_we(inst_we), .inst_sel(inst_sel),
    .inst_addr(inst_addr), .inst_data_w(inst_data_w), .inst_data_r(b_inst_data_r),
    .inst_ack(b_inst_ack), .inst_err(b_inst_err),
    .data_cyc(data_cyc), .data_stb(data_stb), .data_we(data_we), .data_sel(data_sel),
    .data_addr(data_addr), .data_data_w(data_data_w), .data_data_r(b_data_data_r),
    .data_ack(b_data_ack), .data_err(b_data_err),
    .mem_cyc(b_mem_cyc), .mem_stb(b_mem_stb), .mem_we(b_mem_we), .mem_sel(b_mem_sel),
    .mem_addr(b_mem_addr), .mem_data_w(b_mem_data_w), .mem_data_r(mem_data_r),
    .mem_ack(b_mem_ack)
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [11:0] exp_cyc, exp_iack, exp_dack, exp_b_dack;
  int          ack_total;

  initial begin
    // ---------------- reset state ----------------
    step();
    step();
    chk("rst_mem_cyc", a_mem_cyc, 1'b0);
    chk("rst_mem_stb", a_mem_stb, 1'b0);
    chk("rst_mem_we", a_mem_we, 1'b0);
    chk("rst_mem_sel", a_mem_sel, 4'h0);
    chk("rst_mem_addr", a_mem_addr, 32'h0);
    chk("rst_mem_data_w", a_mem_data_w, 32'h0);
    chk("rst_acks", {a_inst_ack, a_data_ack}, 2'b00);
    chk("rst_errs", {a_inst_err, a_data_err}, 2'b00);
    chk("rst_data_r_mirror", a_inst_data_r, 32'h5A5A5A5A);
    chk("rst_data_r_mirror_d", a_data_data_r, 32'h5A5A5A5A);
    rst = 1'b0;
    $display("reset check done");

    // ---------------- 1: single requester ----------------
    inst_cyc = 1'b1; inst_stb = 1'b1; inst_we = 1'b0; inst_sel = 4'hF; inst_addr = 32'h100;
    mem_data_r = 32'hCAFEBABE; slave_en = 1'b1; ack_delay = 2;
    step();
    chk("t1_mem_cyc", a_mem_cyc, 1'b1);
    chk("t1_mem_addr", a_mem_addr, 32'h100);
    chk("t1_mem_we", a_mem_we, 1'b0);
    chk("t1_ack_c1", {a_inst_ack, a_data_ack}, 2'b00);
    step();
    chk("t1_ack_c2", {a_inst_ack, a_data_ack}, 2'b00);
    step();
    chk("t1_inst_ack", a_inst_ack, 1'b1);
    chk("t1_inst_data_r", a_inst_data_r, 32'hCAFEBABE);
    chk("t1_data_ack", a_data_ack, 1'b0);
    inst_cyc = 1'b0; inst_stb = 1'b0;
    step();
    chk("t1_idle_cyc", a_mem_cyc, 1'b0);
    chk("t1_ack_after", {a_inst_ack, a_data_ack}, 2'b00);
    $display("test 1 single requester done");

    // ---------------- 2 + 3: continuous tie ----------------
    do_reset();
    inst_cyc = 1'b1; inst_stb = 1'b1; inst_addr = 32'h100;
    data_cyc = 1'b1; data_stb = 1'b1; data_we = 1'b0; data_addr = 32'h2000; data_sel = 4'hF;
    ack_delay = 1;
    exp_cyc    = 12'b110110110110;
    exp_iack   = 12'b010000010000;
    exp_dack   = 12'b000010000010;
    exp_b_dack = 12'b010010010010;
    ack_total  = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("t2_cyc_%0d", k + 1), a_mem_cyc, exp_cyc[11-k]);
      chk($sformatf("t2_iack_%0d", k + 1), a_inst_ack, exp_iack[11-k]);
      chk($sformatf("t2_dack_%0d", k + 1), a_data_ack, exp_dack[11-k]);
      chk($sformatf("t3_b_dack_%0d", k + 1), b_data_ack, exp_b_dack[11-k]);
      chk($sformatf("t3_b_iack_%0d", k + 1), b_inst_ack, 1'b0);
      if (k == 0 || k == 6) chk($sformatf("t2_addr_%0d", k + 1), a_mem_addr, 32'h100);
      if (k == 3 || k == 9) chk($sformatf("t2_addr_%0d", k + 1), a_mem_addr, 32'h2000);
      if (a_inst_ack || a_data_ack) ack_total++;
    end
    chk("t2_ack_total", ack_total, 4);
    $display("test 2/3 tie sequence done, acks=%0d", ack_total);
    data_cyc = 1'b0; data_stb = 1'b0;
    step();
    chk("t3_b_inst_grant", b_mem_cyc, 1'b1);
    chk("t3_b_inst_addr", b_mem_addr, 32'h100);
    step();
    chk("t3_b_inst_ack", b_inst_ack, 1'b1);
    chk("t3_a_inst_ack", a_inst_ack, 1'b1);
    inst_cyc = 1'b0; inst_stb = 1'b0;
    step();
    chk("t3_idle", a_mem_cyc, 1'b0);
    $display("test 3 priority handover done");

    // ---------------- 4: data write ----------------
    data_cyc = 1'b1; data_stb = 1'b1; data_we = 1'b1; data_addr = 32'h2000;
    data_sel = 4'b0011; data_data_w = 32'h12345678; ack_delay = 2;
    step();
    chk("t4_we", a_mem_we, 1'b1);
    chk("t4_sel", a_mem_sel, 4'b0011);
    chk("t4_data_w", a_mem_data_w, 32'h12345678);
    chk("t4_addr", a_mem_addr, 32'h2000);
    data_addr = 32'hDEAD0000; data_data_w = 32'h0;
    step();
    chk("t4_latched_addr", a_mem_addr, 32'h2000);
    chk("t4_latched_data", a_mem_data_w, 32'h12345678);
    chk("t4_latched_we", a_mem_we, 1'b1);
    chk("t4_no_ack_yet", a_data_ack, 1'b0);
    step();
    chk("t4_data_ack", a_data_ack, 1'b1);
    chk("t4_inst_ack", a_inst_ack, 1'b0);
    data_cyc = 1'b0; data_stb = 1'b0; data_we = 1'b0;
    step();
    chk("t4_idle", a_mem_cyc, 1'b0);
    $display("test 4 data write done");

    // ---------------- 5: timeout ----------------
    slave_en = 1'b0;
    inst_cyc = 1'b1; inst_stb = 1'b1; inst_we = 1'b0; inst_addr = 32'h500;
    step();
    chk("t5_grant", a_mem_cyc, 1'b1);
    chk("t5_addr", a_mem_addr, 32'h500);
    data_cyc = 1'b1; data_stb = 1'b1; data_addr = 32'h3000; data_sel = 4'hF;
    for (int k = 2; k <= 8; k++) begin
      step();
      chk($sformatf("t5_cyc_%0d", k), a_mem_cyc, 1'b1);
      chk($sformatf("t5_noerr_%0d", k), a_inst_err, 1'b0);
    end
    step();
    chk("t5_err", a_inst_err, 1'b1);
    chk("t5_cyc_drop", a_mem_cyc, 1'b0);
    chk("t5_no_ack", a_inst_ack, 1'b0);
    chk("t5_data_err", a_data_err, 1'b0);
    inst_cyc = 1'b0; inst_stb = 1'b0;
    step();
    chk("t5_err_pulse", a_inst_err, 1'b0);
    chk("t5_data_grant", a_mem_cyc, 1'b1);
    chk("t5_data_addr", a_mem_addr, 32'h3000);
    slave_en = 1'b1; ack_delay = 2;
    step();
    chk("t5_data_wait", a_data_ack, 1'b0);
    step();
    chk("t5_data_ack", a_data_ack, 1'b1);
    chk("t5_data_noerr", a_data_err, 1'b0);
    data_cyc = 1'b0; data_stb = 1'b0;
    slave_en = 1'b0;
    step();
    chk("t5_idle", a_mem_cyc, 1'b0);
    stray_ack = 1'b1;
    #1;
    chk("t5_stray_acks", {a_inst_ack, a_data_ack}, 2'b00);
    step();
    chk("t5_stray_acks2", {a_inst_ack, a_data_ack}, 2'b00);
    chk("t5_stray_cyc", a_mem_cyc, 1'b0);
    stray_ack = 1'b0;
    $display("test 5 timeout done");

    // ---------------- 6a: abort ----------------
    inst_cyc = 1'b1; inst_stb = 1'b1; inst_addr = 32'h600;
    step();
    chk("t6_grant", a_mem_cyc, 1'b1);
    step();
    chk("t6_still", a_mem_cyc, 1'b1);
    inst_cyc = 1'b0;
    step();
    chk("t6_abort_cyc", a_mem_cyc, 1'b0);
    chk("t6_abort_ack", a_inst_ack, 1'b0);
    chk("t6_abort_err", a_inst_err, 1'b0);
    inst_stb = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("t6_quiet_%0d", k), {a_mem_cyc, a_inst_err, a_inst_ack}, 3'b000);
    end
    $display("test 6 abort done");

    // ---------------- 6b: reset mid-grant ----------------
    inst_cyc = 1'b1; inst_stb = 1'b1; inst_we = 1'b0; inst_addr = 32'h400; inst_sel = 4'hF;
    data_cyc = 1'b1; data_stb = 1'b1; data_we = 1'b1; data_addr = 32'h800; data_sel = 4'hF;
    data_data_w = 32'h55;
    step();
    chk("t6r_grant", a_mem_cyc, 1'b1);
    step();
    chk("t6r_mid", a_mem_cyc, 1'b1);
    rst = 1'b1;
    step();
    chk("t6r_cyc", a_mem_cyc, 1'b0);
    chk("t6r_stb", a_mem_stb, 1'b0);
    chk("t6r_we", a_mem_we, 1'b0);
    chk("t6r_sel", a_mem_sel, 4'h0);
    chk("t6r_addr", a_mem_addr, 32'h0);
    chk("t6r_data_w", a_mem_data_w, 32'h0);
    chk("t6r_acks_errs", {a_inst_ack, a_data_ack, a_inst_err, a_data_err}, 4'h0);
    chk("t6r_b_cyc", b_mem_cyc, 1'b0);
    rst = 1'b0;
    step();
    chk("t6r_tie_cyc", a_mem_cyc, 1'b1);
    chk("t6r_tie_inst", a_mem_addr, 32'h400);
    chk("t6r_tie_we", a_mem_we, 1'b0);
    chk("t6r_b_data", b_mem_addr, 32'h800);
    chk("t6r_b_we", b_mem_we, 1'b1);
    inst_cyc = 1'b0; inst_stb = 1'b0; data_cyc = 1'b0; data_stb = 1'b0;
    step();
    step();
    $display("test 6 reset done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Two-master, one-slave Wishbone (classic) arbiter that lets the core's instruction-fetch port and data port share a single memory port when only one memory is attached to the Controller. It sits between the processor wrapper's `core_*` / `data_mem_*` buses and the Controller's single `core_*` slave. It grants one transaction at a time, alternates fairly between the two masters, and recovers from a silent slave with a bus-error timeout.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; `sel` width is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 255, cycles after grant with no `mem_ack` before an error is returned; legal range 2..65535.
- `DATA_PRIORITY`, 0, 0 = round-robin; 1 = data master always wins a simultaneous request.

Ports (`X` stands for `inst` or `data`):
- `clk_core` in 1: the single clock.
- `rst_core` in 1: synchronous, active-high reset.
- `X_cyc`, `X_stb`, `X_we` in 1: master request.
- `X_sel` in DATA_WIDTH/8: byte selects.
- `X_addr` in ADDR_WIDTH: address.
- `X_data_w` in DATA_WIDTH: master write data.
- `X_data_r` out DATA_WIDTH: read data to the master.
- `X_ack` out 1: transaction done.
- `X_err` out 1: timeout error.
- `mem_cyc`, `mem_stb`, `mem_we` out 1: slave request.
- `mem_sel` out DATA_WIDTH/8.
- `mem_addr` out ADDR_WIDTH.
- `mem_data_w` out DATA_WIDTH.
- `mem_data_r` in DATA_WIDTH.
- `mem_ack` in 1.

## Operation
- **States:** IDLE, GRANT_INST, GRANT_DATA. A 1-bit `last` register records the master served most recently.
- **Request:** a master is requesting when `X_cyc & X_stb`.
- **IDLE:**
  - Only one master requesting: grant that master.
  - Both requesting, `DATA_PRIORITY=0`: grant the master that is not `last`.
  - Both requesting, `DATA_PRIORITY=1`: grant data.
  - On grant, latch that master's `we/sel/addr/data_w` into the request registers. Clear the timeout counter. Set `last`.
- **GRANT_x:**
  - `mem_cyc = mem_stb = 1`; `mem_we/sel/addr/data_w` come from the latched registers.
  - `mem_data_r` is forwarded to both `X_data_r` at all times; masters qualify it with `X_ack`.
  - `X_ack` of the granted master = `mem_ack` (combinational). The other master's ack is 0.
  - `mem_ack` seen → return to IDLE.
  - Granted master drops `X_cyc` before ack (abort) → return to IDLE, no ack issued. The slave sees `mem_cyc` low next cycle.
  - Timeout counter increments every GRANT cycle. When it equals `TIMEOUT_CYCLES-1` with no `mem_ack` that cycle:
    - pulse the granted master's `X_err` for exactly 1 cycle (registered, the cycle after);
    - go to IDLE.
  - `mem_ack` and timeout expiring in the same cycle: ack wins, no err.
- **Stray ack:** `mem_ack` while IDLE is ignored and forwarded to nobody.
- **Counter width:** `$clog2(TIMEOUT_CYCLES+1)` bits; the counter saturates and never wraps.
- **Reset:** at any point, including mid-transaction:
  - state IDLE, `last` = data (so inst wins the first tie);
  - counter 0, request registers 0;
  - the slave is abandoned without handshake.

## Timing
- **Reset values:** all outputs 0, including `mem_cyc`, `mem_stb`, `mem_we`, `mem_sel`, `mem_addr`, `mem_data_w`, `X_ack`, `X_err`. `X_data_r` mirrors `mem_data_r`.
- **Request to slave:** request sampled in IDLE at edge N → `mem_cyc/stb` high from edge N through the edge where `mem_ack` is seen (1 cycle request-to-slave latency).
- **Ack path:** `mem_ack` to `X_ack` has 0 latency (same cycle).
- **Mandatory idle:** after ack, err, or abort, `mem_cyc` is low for at least 1 cycle.
  - Single-cycle-ack slave throughput is therefore 1 transfer per 3 cycles (grant, ack, idle).
- **Master obligations:** masters follow classic Wishbone and hold `cyc/stb/addr/data` until ack or err. Changes to master signals after grant are not propagated, because the latched copy is used.
- **Err timing:** `X_err` is asserted exactly on the cycle after the expiry cycle.
  - Err is high for exactly 1 cycle.
  - Err is never asserted simultaneously with `X_ack`.

## Test plan
1. **Single requester.** Inst reads `0x100`; slave acks 2 cycles after `mem_stb` with `0xCAFEBABE`.
   - Expect `mem_addr=0x100`.
   - Expect `inst_ack` for 1 cycle with `inst_data_r=0xCAFEBABE`.
   - Expect `data_ack=0` throughout.
2. **Tie, round-robin.** Both masters request continuously from reset; slave acks in 1 cycle.
   - Grants alternate inst, data, inst, data.
   - Exactly 4 acks in 12 cycles.
   - `mem_cyc` low 1 cycle between grants.
3. **`DATA_PRIORITY=1`.** Both request continuously.
   - Every grant goes to data.
   - Inst gets a grant only once data drops `cyc`.
4. **Data write.** Data writes `0x12345678` to `0x2000` with `sel=4'b0011`.
   - Expect `mem_we=1`, `mem_sel=0011`, `mem_data_w=0x12345678` on the slave port until ack.
5. **Timeout.** `TIMEOUT_CYCLES=8`, slave never acks an inst read.
   - `inst_err` pulses once, 8 cycles after grant.
   - `mem_cyc` drops.
   - A pending data request is granted next.
   - A late `mem_ack` in IDLE is not forwarded.
6. **Abort and reset.**
   - Inst drops `cyc` mid-wait → `mem_cyc` low next cycle, no ack or err.
   - Separately, assert `rst_core` mid-grant → all outputs 0 next cycle; inst wins the first post-reset tie.
